// File: rtl/lstm_fwd_seq.sv
// Sequential forward pass of a single LSTM cell over a fixed-length sequence.
// One multiply-accumulate per input per cycle for all four gates in parallel,
// then one cycle of activations and one cycle of cell/hidden state update per
// timestep. Every per-timestep intermediate is kept for a later backward pass.
module lstm_fwd_seq #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int TIMESTEP = 4,
  parameter int NUM      = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [TIMESTEP*(NUM-1)*WIDTH-1:0]   i_x,
  input  logic [NUM*WIDTH-1:0]                i_wa,
  input  logic [NUM*WIDTH-1:0]                i_wi,
  input  logic [NUM*WIDTH-1:0]                i_wf,
  input  logic [NUM*WIDTH-1:0]                i_wo,
  input  logic [4*WIDTH-1:0]                  i_b,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [TIMESTEP*WIDTH-1:0]           o_h,
  output logic [TIMESTEP*WIDTH-1:0]           o_c,
  output logic [TIMESTEP*WIDTH-1:0]           o_a,
  output logic [TIMESTEP*WIDTH-1:0]           o_i,
  output logic [TIMESTEP*WIDTH-1:0]           o_f,
  output logic [TIMESTEP*WIDTH-1:0]           o_o,
  output logic [TIMESTEP*NUM*WIDTH-1:0]       o_x
);

  localparam int NX = TIMESTEP * (NUM - 1);
  localparam int NO = TIMESTEP * NUM;
  localparam int TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam int KW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int OW = (NO > 1) ? $clog2(NO) : 1;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_DONE} state_t;

  localparam word_t ONE  = WIDTH'(1) << FRAC;
  localparam word_t MONE = -ONE;
  localparam word_t HALF = ONE >>> 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM - 1);

  // Fixed-point product: full-width multiply, rescale, keep the low word.
  function automatic word_t f_mul(input word_t a, input word_t b);
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    p = p >>> FRAC;
    return p[WIDTH-1:0];
  endfunction

  // Hard sigmoid: slope 1/4 through 0.5, clamped to [0, 1].
  function automatic word_t f_sig(input word_t x);
    word_t s;
    s = (x >>> 2) + HALF;
    if (s[WIDTH-1])  return '0;
    if (s > ONE)     return ONE;
    return s;
  endfunction

  // Hard tanh: identity clamped to [-1, 1].
  function automatic word_t f_tanh(input word_t x);
    if (x > ONE)  return ONE;
    if (x < MONE) return MONE;
    return x;
  endfunction

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [TW-1:0] r_t;
  logic [KW-1:0] r_k;

  // Operands captured at start
  word_t r_x  [NX];
  word_t r_wa [NUM];
  word_t r_wi [NUM];
  word_t r_wf [NUM];
  word_t r_wo [NUM];
  word_t r_ba, r_bi, r_bf, r_bo;

  // Working state
  word_t r_acc_a, r_acc_i, r_acc_f, r_acc_o;
  word_t r_ga, r_gi, r_gf, r_go;
  word_t r_h_prev, r_c_prev;

  // Per-timestep results
  word_t r_h [TIMESTEP];
  word_t r_c [TIMESTEP];
  word_t r_a [TIMESTEP];
  word_t r_i [TIMESTEP];
  word_t r_f [TIMESTEP];
  word_t r_o [TIMESTEP];
  word_t r_ox [NO];

  logic [XW-1:0] w_xidx;
  logic [OW-1:0] w_oxidx;
  word_t w_in;
  word_t w_pa, w_pi, w_pf, w_po;
  word_t w_act_a, w_act_i, w_act_f, w_act_o;
  word_t w_c, w_h;

  // Operand select, gate products, activations and the cell update
  always_comb begin
    w_xidx  = '0;
    w_oxidx = OW'((int'(r_t) + 1) * NUM + (NUM - 1));
    if (r_k != K_LAST)
      w_xidx = XW'(int'(r_t) * (NUM - 1) + int'(r_k));
    w_in    = (r_k == K_LAST) ? r_h_prev : r_x[w_xidx];
    w_pa    = f_mul(r_wa[r_k], w_in);
    w_pi    = f_mul(r_wi[r_k], w_in);
    w_pf    = f_mul(r_wf[r_k], w_in);
    w_po    = f_mul(r_wo[r_k], w_in);
    w_act_a = f_tanh(r_acc_a);
    w_act_i = f_sig(r_acc_i);
    w_act_f = f_sig(r_acc_f);
    w_act_o = f_sig(r_acc_o);
    w_c     = f_mul(r_ga, r_gi) + f_mul(r_gf, r_c_prev);
    w_h     = f_mul(f_tanh(w_c), r_go);
  end

  // Capture inputs on an accepted start so later input changes are ignored
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == S_IDLE && i_start) begin
      for (int j = 0; j < NX; j++)
        r_x[j] <= i_x[j*WIDTH +: WIDTH];
      for (int k = 0; k < NUM; k++) begin
        r_wa[k] <= i_wa[k*WIDTH +: WIDTH];
        r_wi[k] <= i_wi[k*WIDTH +: WIDTH];
        r_wf[k] <= i_wf[k*WIDTH +: WIDTH];
        r_wo[k] <= i_wo[k*WIDTH +: WIDTH];
      end
      r_ba <= i_b[0*WIDTH +: WIDTH];
      r_bi <= i_b[1*WIDTH +: WIDTH];
      r_bf <= i_b[2*WIDTH +: WIDTH];
      r_bo <= i_b[3*WIDTH +: WIDTH];
    end
  end

  // Sequencer: MAC over inputs, activate, update cell, repeat per timestep
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_t      <= '0;
      r_k      <= '0;
      r_acc_a  <= '0;
      r_acc_i  <= '0;
      r_acc_f  <= '0;
      r_acc_o  <= '0;
      r_ga     <= '0;
      r_gi     <= '0;
      r_gf     <= '0;
      r_go     <= '0;
      r_h_prev <= '0;
      r_c_prev <= '0;
      for (int j = 0; j < TIMESTEP; j++) begin
        r_h[j] <= '0;
        r_c[j] <= '0;
        r_a[j] <= '0;
        r_i[j] <= '0;
        r_f[j] <= '0;
        r_o[j] <= '0;
      end
      for (int j = 0; j < NO; j++)
        r_ox[j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_MAC;
            r_busy   <= 1'b1;
            r_t      <= '0;
            r_k      <= '0;
            r_h_prev <= '0;
            r_c_prev <= '0;
            r_acc_a  <= i_b[0*WIDTH +: WIDTH];
            r_acc_i  <= i_b[1*WIDTH +: WIDTH];
            r_acc_f  <= i_b[2*WIDTH +: WIDTH];
            r_acc_o  <= i_b[3*WIDTH +: WIDTH];
            for (int j = 0; j < TIMESTEP; j++) begin
              r_h[j] <= '0;
              r_c[j] <= '0;
              r_a[j] <= '0;
              r_i[j] <= '0;
              r_f[j] <= '0;
              r_o[j] <= '0;
              // External inputs are echoed now; recurrent slots fill in as h is produced
              for (int k = 0; k < NUM - 1; k++)
                r_ox[j*NUM + k] <= i_x[(j*(NUM-1) + k)*WIDTH +: WIDTH];
              r_ox[j*NUM + NUM - 1] <= '0;
            end
          end
        end
        S_MAC: begin
          r_acc_a <= r_acc_a + w_pa;
          r_acc_i <= r_acc_i + w_pi;
          r_acc_f <= r_acc_f + w_pf;
          r_acc_o <= r_acc_o + w_po;
          if (r_k == K_LAST)
            r_state <= S_ACT;
          else
            r_k <= r_k + 1'b1;
        end
        S_ACT: begin
          r_ga     <= w_act_a;
          r_gi     <= w_act_i;
          r_gf     <= w_act_f;
          r_go     <= w_act_o;
          r_a[r_t] <= w_act_a;
          r_i[r_t] <= w_act_i;
          r_f[r_t] <= w_act_f;
          r_o[r_t] <= w_act_o;
          r_state  <= S_UPD;
        end
        S_UPD: begin
          r_c[r_t] <= w_c;
          r_h[r_t] <= w_h;
          r_c_prev <= w_c;
          r_h_prev <= w_h;
          if (r_t == T_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_ox[w_oxidx] <= w_h;
            r_t     <= r_t + 1'b1;
            r_k     <= '0;
            r_acc_a <= r_ba;
            r_acc_i <= r_bi;
            r_acc_f <= r_bf;
            r_acc_o <= r_bo;
            r_state <= S_MAC;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

  for (genvar j = 0; j < TIMESTEP; j++) begin : g_out
    assign o_h[j*WIDTH +: WIDTH] = r_h[j];
    assign o_c[j*WIDTH +: WIDTH] = r_c[j];
    assign o_a[j*WIDTH +: WIDTH] = r_a[j];
    assign o_i[j*WIDTH +: WIDTH] = r_i[j];
    assign o_f[j*WIDTH +: WIDTH] = r_f[j];
    assign o_o[j*WIDTH +: WIDTH] = r_o[j];
  end

  for (genvar j = 0; j < NO; j++) begin : g_ox
    assign o_x[j*WIDTH +: WIDTH] = r_ox[j];
  end

endmodule

// File: tb/tb_lstm_fwd_seq.sv
// Scoreboard bench for lstm_fwd_seq: stimulus pushes the expected result set,
// a monitor pops and compares it whenever o_done is presented.
module tb_lstm_fwd_seq;
  localparam int W  = 32;
  localparam int FR = 24;
  localparam int T  = 4;
  localparam int N  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, start;
  logic [T*(N-1)*W-1:0]     x_v;
  logic [N*W-1:0]           wa_v, wi_v, wf_v, wo_v;
  logic [4*W-1:0]           b_v;
  logic                     busy, done;
  logic [T*W-1:0]           h, c, a, ig, fg, og;
  logic [T*N*W-1:0]         ox;

  lstm_fwd_seq #(.WIDTH(W), .FRAC(FR), .TIMESTEP(T), .NUM(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_x(x_v),
    .i_wa(wa_v), .i_wi(wi_v), .i_wf(wf_v), .i_wo(wo_v), .i_b(b_v),
    .o_busy(busy), .o_done(done),
    .o_h(h), .o_c(c), .o_a(a), .o_i(ig), .o_f(fg), .o_o(og), .o_x(ox)
  );

  typedef struct {
    logic [T*W-1:0]   h, c, a, i, f, o;
    logic [T*N*W-1:0] x;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 required no pulse at %0t", $time);
      end else begin
        e = q.pop_front();
        check("o_h", h,  e.h);
        check("o_c", c,  e.c);
        check("o_a", a,  e.a);
        check("o_i", ig, e.i);
        check("o_f", fg, e.f);
        check("o_o", og, e.o);
        check("o_x", ox, e.x);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic signed [31:0] fm(input logic signed [31:0] x, input logic signed [31:0] y);
    longint p;
    p = longint'(x) * longint'(y);
    p = p >>> FR;
    return p[31:0];
  endfunction

  function automatic logic signed [31:0] fsig(input logic signed [31:0] x);
    logic signed [31:0] s;
    s = (x >>> 2) + 32'sh00800000;
    if (s < 0) return 32'sh0;
    if (s > 32'sh01000000) return 32'sh01000000;
    return s;
  endfunction

  function automatic logic signed [31:0] fth(input logic signed [31:0] x);
    if (x > 32'sh01000000) return 32'sh01000000;
    if (x < -32'sh01000000) return -32'sh01000000;
    return x;
  endfunction

  function automatic logic signed [31:0] wsel(input int g, input int k);
    case (g)
      0:       return wa_v[k*W +: W];
      1:       return wi_v[k*W +: W];
      2:       return wf_v[k*W +: W];
      default: return wo_v[k*W +: W];
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic signed [31:0] acc[4];
    logic signed [31:0] hp, cp, inp, av, iv, fv, ovv, cv, hv;
    e.h = '0; e.c = '0; e.a = '0; e.i = '0; e.f = '0; e.o = '0; e.x = '0;
    hp = 0; cp = 0;
    for (int t = 0; t < T; t++) begin
      for (int g = 0; g < 4; g++) acc[g] = b_v[g*W +: W];
      for (int k = 0; k < N; k++) begin
        if (k < N-1) inp = x_v[(t*(N-1)+k)*W +: W];
        else         inp = hp;
        for (int g = 0; g < 4; g++) acc[g] = acc[g] + fm(wsel(g, k), inp);
      end
      av = fth(acc[0]); iv = fsig(acc[1]); fv = fsig(acc[2]); ovv = fsig(acc[3]);
      for (int k = 0; k < N-1; k++) e.x[(t*N+k)*W +: W] = x_v[(t*(N-1)+k)*W +: W];
      e.x[(t*N+N-1)*W +: W] = hp;
      cv = fm(av, iv) + fm(fv, cp);
      hv = fm(fth(cv), ovv);
      e.a[t*W +: W] = av; e.i[t*W +: W] = iv; e.f[t*W +: W] = fv; e.o[t*W +: W] = ovv;
      e.c[t*W +: W] = cv; e.h[t*W +: W] = hv;
      cp = cv; hp = hv;
    end
    return e;
  endfunction

  function automatic logic [31:0] rv();
    int r;
    r = int'($urandom_range(0, 32'h07FFFFFF)) - 32'h04000000;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [T*W-1:0] HALF4 = {4{32'h00800000}};
  localparam logic [T*(N-1)*W-1:0] XDIR = {32'h04000000, 32'h03000000, 32'h02000000, 32'h01000000};

  task automatic set_zero();
    x_v = XDIR; wa_v = '0; wi_v = '0; wf_v = '0; wo_v = '0; b_v = '0;
  endtask

  task automatic run_seq(input exp_t e, input bit hold, input bit scramble);
    int n;
    @(negedge clk);
    start = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    if (scramble) begin
      x_v = ~x_v; wa_v = ~wa_v; wi_v = ~wi_v; wf_v = ~wf_v; wo_v = ~wo_v; b_v = ~b_v;
    end
    check("busy_running", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_latency", n, 16);
    check("busy_in_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
  endtask

  exp_t e_zero, e_ba, e_sat;

  initial begin
    // Hand-computed expectations
    e_zero.h = '0; e_zero.c = '0; e_zero.a = '0;
    e_zero.i = HALF4; e_zero.f = HALF4; e_zero.o = HALF4;
    e_zero.x = {32'h0, 32'h04000000, 32'h0, 32'h03000000, 32'h0, 32'h02000000, 32'h0, 32'h01000000};

    e_ba.a = {4{32'h01000000}};
    e_ba.i = HALF4; e_ba.f = HALF4; e_ba.o = HALF4;
    e_ba.c = {32'h00F00000, 32'h00E00000, 32'h00C00000, 32'h00800000};
    e_ba.h = {32'h00780000, 32'h00700000, 32'h00600000, 32'h00400000};
    e_ba.x = {32'h00700000, 32'h04000000, 32'h00600000, 32'h03000000,
              32'h00400000, 32'h02000000, 32'h0, 32'h01000000};

    e_sat.a = {4{32'hFF000000}};
    e_sat.i = {4{32'h01000000}};
    e_sat.f = HALF4; e_sat.o = HALF4;
    e_sat.c = {32'hFE200000, 32'hFE400000, 32'hFE800000, 32'hFF000000};
    e_sat.h = {4{32'hFF800000}};
    e_sat.x = {32'hFF800000, 32'h04000000, 32'hFF800000, 32'h03000000,
               32'hFF800000, 32'h02000000, 32'h0, 32'h01000000};

    rst = 1'b1; start = 1'b1; set_zero();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_h", h, 0);
    check("rst_ox", ox, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // All-zero weights and biases
    set_zero();
    run_seq(e_zero, 1'b0, 1'b0);

    // Candidate bias of 1.0 builds up the cell state
    set_zero(); b_v[0*W +: W] = 32'h01000000;
    run_seq(e_ba, 1'b0, 1'b0);

    // Saturating activations
    set_zero(); b_v[1*W +: W] = 32'h08000000; b_v[0*W +: W] = 32'hF8000000;
    run_seq(e_sat, 1'b0, 1'b0);

    // Start held high and inputs disturbed during the run
    set_zero(); b_v[0*W +: W] = 32'h01000000;
    run_seq(e_ba, 1'b1, 1'b1);

    // Reset in the middle of a sequence
    set_zero(); b_v[0*W +: W] = 32'h01000000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_abort", busy, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_h", h, 0);
    check("abort_c", c, 0);
    check("abort_i", ig, 0);
    check("abort_ox", ox, 0);
    @(negedge clk); rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);
    run_seq(e_ba, 1'b0, 1'b0);

    // Random operands against the reference model
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < T*(N-1); j++) x_v[j*W +: W] = rv();
      for (int k = 0; k < N; k++) begin
        wa_v[k*W +: W] = rv(); wi_v[k*W +: W] = rv();
        wf_v[k*W +: W] = rv(); wo_v[k*W +: W] = rv();
      end
      for (int g = 0; g < 4; g++) b_v[g*W +: W] = rv();
      run_seq(model(), 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lstm_fwd_seq.md
LSTM_FWD_SEQ -- requirements
Module: lstm_fwd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the fixed-point word width.
REQ-002 The block SHALL have parameter FRAC, default 24, giving the number of fraction bits.
REQ-003 The block SHALL have parameter TIMESTEP, default 4, giving the number of timesteps per sequence.
REQ-004 The block SHALL have parameter NUM, default 2, giving the number of external inputs plus one for the previous output.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port i_start, input, 1 bit: request to start a sequence.
REQ-008 The block SHALL have port i_x, input, TIMESTEP*(NUM-1)*WIDTH bits: external inputs; timestep j, input k is at slot j*(NUM-1)+k.
REQ-009 The block SHALL have ports i_wa, i_wi, i_wf and i_wo, input, NUM*WIDTH bits each: gate weights; slot NUM-1 is the recurrent weight U.
REQ-010 The block SHALL have port i_b, input, 4*WIDTH bits: biases, packed {o,f,i,a} with a in the LSB slot.
REQ-011 The block SHALL have port o_busy, output, 1 bit: a sequence is in progress.
REQ-012 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when all outputs are valid.
REQ-013 The block SHALL have ports o_h, o_c, o_a, o_i, o_f and o_o, output, TIMESTEP*WIDTH bits each: per-timestep results, first timestep in slot 0.
REQ-014 The block SHALL have port o_x, output, TIMESTEP*NUM*WIDTH bits: the backprop input vector.
  - Timestep j, slot k<NUM-1 = i_x input k.
  - Timestep j, slot NUM-1 = h of timestep j-1, or 0 for j=0.

Function
REQ-015 All arithmetic SHALL be two's-complement Q(WIDTH-FRAC).FRAC.
  - Product = full 2*WIDTH-bit product, arithmetic-shifted right by FRAC, truncated to the low WIDTH bits.
  - Sums wrap at WIDTH bits, with no saturation.
REQ-016 Activations SHALL be the following piecewise-linear functions:
  - sig(x) = clamp((x>>>2) + 0.5, 0, 1.0).
  - tanh(x) = clamp(x, -1.0, +1.0).
REQ-017 The FSM SHALL have the states IDLE, MAC, ACT, UPD and DONE.
REQ-018 In IDLE, i_start=1 SHALL do all of the following:
  - Latch i_x, the weights and i_b.
  - Clear h_prev and c_prev to 0.
  - Set timestep counter t=0 and input counter k=0.
  - Load the four pre-activation accumulators with their biases.
  - Go to MAC.
REQ-019 In MAC, each cycle SHALL add w_g[k]*in_k to each of the four accumulators in parallel.
  - in_k = the latched x for (t,k) when k<NUM-1.
  - in_k = h_prev when k=NUM-1.
  - After k=NUM-1 the FSM goes to ACT; otherwise k increments.
REQ-020 ACT SHALL register a=tanh(acc_a), i=sig(acc_i), f=sig(acc_f) and o=sig(acc_o) into slot t, then go to UPD.
REQ-021 UPD SHALL perform the cell update for slot t:
  - c = a*i + f*c_prev.
  - h = tanh(c)*o.
  - Write c and h into slot t; set c_prev=c and h_prev=h.
  - Write h into o_x slot (t+1, NUM-1) when t<TIMESTEP-1.
REQ-022 On leaving UPD, the FSM SHALL go to DONE if t=TIMESTEP-1.
  - Otherwise t increments, k=0, the accumulators reload the biases, and the FSM goes to MAC.
REQ-023 DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-024 o_busy SHALL be 1 in MAC, ACT and UPD, and 0 in IDLE and DONE.
REQ-025 Latency SHALL be TIMESTEP*(NUM+2) cycles from the start-sampling edge to the edge that enters DONE.
  - o_done is high in cycle TIMESTEP*(NUM+2)+1 after that edge (17 cycles at the defaults).
REQ-026 i_start outside IDLE SHALL be ignored, and input changes after latching SHALL have no effect on the running sequence.
REQ-027 Output arrays SHALL hold their values from DONE until the next accepted start, which clears them to 0.
REQ-028 Every output slot SHALL be written exactly once per sequence.

Reset
REQ-029 i_rst=1 at a clock edge SHALL force IDLE, clear o_busy and o_done, and clear all output arrays, accumulators, h_prev, c_prev and counters.
REQ-030 Reset SHALL take priority over i_start.
REQ-031 Reset mid-sequence SHALL abort the sequence with no o_done pulse.
REQ-032 The first start after reset SHALL run a complete, correct sequence.

Verification
REQ-033 A bench SHALL drive all weights and biases 0 and pulse start.
  - Required response: o_done in cycle 17.
  - Every o_a, o_c and o_h slot = 0.
  - Every o_i, o_f and o_o slot = 0x00800000.
REQ-034 A bench SHALL drive all weights 0 with b_a=0x01000000 (other biases 0).
  - Required o_c = {0x00F00000, 0x00E00000, 0x00C00000, 0x00800000}.
  - Required o_h = {0x00780000, 0x00700000, 0x00600000, 0x00400000}.
  - o_x recurrent slots = {0x00700000, 0x00600000, 0x00400000, 0}.
REQ-035 A bench SHALL drive b_i=0x08000000 and b_a=0xF8000000 (-8.0).
  - Required response: every o_i slot = 0x01000000 and every o_a slot = 0xFF000000 (sig and tanh saturate).
REQ-036 A bench SHALL assert i_start every cycle during a running sequence.
  - Required response: a single o_done pulse in cycle 17, with results identical to a single start.
REQ-037 A bench SHALL assert i_rst in cycle 7 of a sequence.
  - Required response: o_busy=0 the next cycle, all outputs 0, and no o_done pulse.
  - A following start produces the results of REQ-034.
REQ-038 A bench SHALL run random weights, biases and inputs.
  - Required response: every output bit-matches a reference model implementing REQ-015 to REQ-021.
